clk_sel_ctrl: RTL and testbench

CLK_SEL_CTRL -- requirements
Module: clk_sel_ctrl

---
 rtl/clk_sel_pkg.sv | 21 ++
 rtl/clk_sel_cnt.sv | 26 ++
 rtl/clk_sel_ctrl.sv | 144 ++++++++++++++
 tb/tb_clk_sel_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_sel_pkg.sv
// Shared types and constants for the glitch-free clock-select controller.
package clk_sel_pkg;

  localparam int CNT_W          = 8;
  localparam int GATE_CYC_DEF   = 4;
  localparam int SETTLE_CYC_DEF = 4;
  localparam int LOCK_CYC_DEF   = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GATE   = 2'd1,
    S_SETTLE = 2'd2,
    S_LOCK   = 2'd3
  } state_e;

  // A phase of N cycles is counted as N-1 down to 0.
  function automatic logic [CNT_W-1:0] phase_load(input int cyc);
    return CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/clk_sel_cnt.sv
// Loadable 8-bit down-counter with a zero flag; saturates at zero.
module clk_sel_cnt
  import clk_sel_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/clk_sel_ctrl.sv
// Clock-select sequencer: gate clk_en, switch clk_ctrl, settle, re-enable.
// Optional post-switch lockout is built when CLK_SEL_CTRL_LOCKOUT_EN is defined.
module clk_sel_ctrl
  import clk_sel_pkg::*;
#(
  parameter int GATE_CYC   = GATE_CYC_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int LOCK_CYC   = LOCK_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       req_sel,
  output logic       clk_ctrl,
  output logic       clk_en,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] state
);

  localparam logic [1:0] ST_IDLE   = 2'(S_IDLE);
  localparam logic [1:0] ST_GATE   = 2'(S_GATE);
  localparam logic [1:0] ST_SETTLE = 2'(S_SETTLE);
`ifdef CLK_SEL_CTRL_LOCKOUT_EN
  localparam logic [1:0] ST_LOCK   = 2'(S_LOCK);
`endif

  logic             target;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  clk_sel_cnt u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .value    (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = '0;
    case (state)
      ST_IDLE: begin
        if (req && (req_sel != clk_ctrl)) begin
          cnt_load     = 1'b1;
          cnt_load_val = phase_load(GATE_CYC);
        end
      end
      ST_GATE: begin
        if (cnt_zero) begin
          cnt_load     = 1'b1;
          cnt_load_val = phase_load(SETTLE_CYC);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero) begin
`ifdef CLK_SEL_CTRL_LOCKOUT_EN
          cnt_load     = 1'b1;
          cnt_load_val = phase_load(LOCK_CYC);
`endif
        end else begin
          cnt_dec = 1'b1;
        end
      end
`ifdef CLK_SEL_CTRL_LOCKOUT_EN
      ST_LOCK: begin
        cnt_dec = !cnt_zero;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      target   <= 1'b0;
      clk_ctrl <= 1'b0;
      clk_en   <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (req_sel != clk_ctrl) begin
              target <= req_sel;
              clk_en <= 1'b0;
              busy   <= 1'b1;
              state  <= ST_GATE;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_GATE: begin
          err <= req;
          if (cnt_zero) begin
            clk_ctrl <= target;
            state    <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // On the completing edge done takes precedence so done and err stay exclusive.
          err <= req && !cnt_zero;
          if (cnt_zero) begin
            clk_en <= 1'b1;
            done   <= 1'b1;
`ifdef CLK_SEL_CTRL_LOCKOUT_EN
            state  <= ST_LOCK;
`else
            busy   <= 1'b0;
            state  <= ST_IDLE;
`endif
          end
        end
`ifdef CLK_SEL_CTRL_LOCKOUT_EN
        ST_LOCK: begin
          err <= req;
          if (cnt_zero) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Directed bench for clk_sel_ctrl: scoreboard of done/err events plus cycle-exact output checks.
module tb_clk_sel_ctrl;

`ifdef CLK_SEL_CTRL_LOCKOUT_EN
  localparam logic LB = 1'b1;
`else
  localparam logic LB = 1'b0;
`endif
  localparam int W = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0, req_sel = 1'b0;
  logic       clk_ctrl, clk_en, busy, done, err;
  logic [1:0] state;
  logic       req_b = 1'b0, req_sel_b = 1'b0;
  logic       clk_ctrl_b, clk_en_b, busy_b, done_b, err_b;
  logic [1:0] state_b;

  int cyc = 0;
  int base = 0;
  int n_vec = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_act, mon_exp;

  clk_sel_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .req_sel(req_sel),
    .clk_ctrl(clk_ctrl), .clk_en(clk_en), .busy(busy),
    .done(done), .err(err), .state(state)
  );

  clk_sel_ctrl #(.GATE_CYC(1), .SETTLE_CYC(1)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .req_sel(req_sel_b),
    .clk_ctrl(clk_ctrl_b), .clk_en(clk_en_b), .busy(busy_b),
    .done(done_b), .err(err_b), .state(state_b)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // monitor: every done/err pulse of dut must match the head of the expected queue
  always @(negedge clk) begin
    if (done || err) begin
      mon_act = {err, 16'(cyc - base), clk_ctrl, clk_en, busy};
      n_vec++;
      if (done && err) begin
        n_bad++;
        $display("FAIL done_err_overlap: cycle %0d got done=1 err=1, required exclusive", cyc - base);
      end else if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL event: got unexpected %s at cycle %0d (ctrl=%0b en=%0b busy=%0b), required none",
                 err ? "err" : "done", cyc - base, clk_ctrl, clk_en, busy);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp)
          begin
            n_bad++;
            $display("FAIL event: got err=%0b cyc=%0d ctrl/en/busy=%03b, required err=%0b cyc=%0d ctrl/en/busy=%03b",
                     mon_act[19], mon_act[18:3], mon_act[2:0], mon_exp[19], mon_exp[18:3], mon_exp[2:0]);
          end
      end
    end
  end

  // driver tasks
  task automatic push_ev(input logic is_err, input int k, input logic c, input logic e, input logic b);
    exp_q.push_back({is_err, 16'(k), c, e, b});
  endtask

  task automatic goto(input int k);
    int guard;
    guard = 0;
    while ((cyc - base) < k && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if ((cyc - base) != k) begin
      n_vec++;
      n_bad++;
      $display("FAIL goto: at cycle %0d, required cycle %0d", cyc - base, k);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: cycle %0d got %b, required %b", name, cyc - base, act, exp_v);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; req = 1'b0; req_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    base = cyc;
  endtask

  task automatic pulse(input int k, input logic sel);
    goto(k);
    req = 1'b1; req_sel = sel;
    @(negedge clk);
    req = 1'b0;
  endtask

  initial begin
    // Scenario A: basic switch to clk1, with the short-parameter instance alongside
    reset_dut();
    chk("reset_a", {3'b0, clk_ctrl, clk_en, busy, done, err}, 8'b0000_1000);
    chk("reset_state", {6'b0, state}, 8'd0);
    chk("reset_b", {3'b0, clk_ctrl_b, clk_en_b, busy_b, done_b, err_b}, 8'b0000_1000);
    push_ev(1'b0, 19, 1'b1, 1'b1, LB);
    goto(10);
    req = 1'b1; req_sel = 1'b1; req_b = 1'b1; req_sel_b = 1'b1;
    @(negedge clk);
    req = 1'b0; req_b = 1'b0;
    chk("a11", {5'b0, clk_ctrl, clk_en, busy}, 8'b001);
    chk("b11", {5'b0, clk_ctrl_b, clk_en_b, busy_b}, 8'b001);
    goto(12);
    chk("b12", {5'b0, clk_ctrl_b, clk_en_b, busy_b}, 8'b101);
    goto(13);
    chk("b13", {4'b0, clk_ctrl_b, clk_en_b, busy_b, done_b}, {4'b0, 1'b1, 1'b1, LB, 1'b1});
    goto(14);
    chk("a14", {5'b0, clk_ctrl, clk_en, busy}, 8'b001);
    chk("b14_done", {7'b0, done_b}, 8'd0);
    goto(15);
    chk("a15", {5'b0, clk_ctrl, clk_en, busy}, 8'b101);
    goto(18);
    chk("a18", {5'b0, clk_ctrl, clk_en, busy}, 8'b101);
    goto(19);
    chk("a19", {5'b0, clk_ctrl, clk_en, busy}, {5'b0, 1'b1, 1'b1, LB});
`ifdef CLK_SEL_CTRL_LOCKOUT_EN
    push_ev(1'b1, 26, 1'b1, 1'b1, 1'b1);
    pulse(25, 1'b0);
    goto(34);
    chk("lock34", {7'b0, busy}, 8'd1);
    goto(35);
    chk("lock35", {7'b0, busy}, 8'd0);
`endif

    // Scenario B: request for the already-selected clock
    push_ev(1'b0, 41, 1'b1, 1'b1, 1'b0);
    pulse(40, 1'b1);
    chk("same41", {5'b0, clk_ctrl, clk_en, busy}, 8'b110);

    // Scenario E: switch back to clk2
    push_ev(1'b0, 59, 1'b0, 1'b1, LB);
    pulse(50, 1'b0);
    chk("back51", {5'b0, clk_ctrl, clk_en, busy}, 8'b101);
    goto(54);
    chk("back54", {5'b0, clk_ctrl, clk_en, busy}, 8'b101);
    goto(55);
    chk("back55", {5'b0, clk_ctrl, clk_en, busy}, 8'b001);
    goto(59);
    chk("back59", {5'b0, clk_ctrl, clk_en, busy}, {5'b0, 1'b0, 1'b1, LB});

    // Scenario C: request mid-sequence rejected; req_sel wiggles ignored
    reset_dut();
    push_ev(1'b1, 14, 1'b0, 1'b0, 1'b1);
    push_ev(1'b0, 19, 1'b1, 1'b1, LB);
    pulse(10, 1'b1);
    pulse(13, 1'b0);
    goto(16);
    req_sel = 1'b0;
    goto(17);
    req_sel = 1'b1;
    goto(18);
    req_sel = 1'b0;
    chk("rej18", {5'b0, clk_ctrl, clk_en, busy}, 8'b101);
    goto(19);
    chk("rej19", {5'b0, clk_ctrl, clk_en, busy}, {5'b0, 1'b1, 1'b1, LB});

    // Scenario D: reset mid-sequence, with a request on the reset edge
    reset_dut();
    pulse(10, 1'b1);
    goto(16);
    rst = 1'b1; req = 1'b1; req_sel = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    chk("rst17", {3'b0, clk_ctrl, clk_en, busy, done, err}, 8'b0000_1000);
    chk("rst17_state", {6'b0, state}, 8'd0);
    goto(22);
    chk("rst22", {3'b0, clk_ctrl, clk_en, busy, done, err}, 8'b0000_1000);

    goto(25);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d pending events, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
